// File: rtl/branch_cmp_unit.sv
// Branch compare with a one-deep registered result and a mispredict counter.
// Optional 2-bit predictor table, built only when BRANCH_PRED_EN is defined.
module branch_cmp_unit #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       CMPOp,
   input  logic [WIDTH-1:0] D_V1,
   input  logic [WIDTH-1:0] D_V2,
   input  logic [WIDTH-1:0] d_pc,
   input  logic             d_pred_taken,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             b_result,
   output logic             mispredict,
   input  logic [WIDTH-1:0] f_pc,
   output logic             f_pred,
   output logic [31:0]      mispredict_cnt
);

   localparam int ENTRIES = 1 << IDX_W;

   logic        out_valid_q, out_valid_d;
   logic        b_result_q, b_result_d;
   logic        mispred_q, mispred_d;
   logic [31:0] mcnt_q, mcnt_d;

   logic taken;
   logic mis;
   logic fire;
   logic v1_neg;
   logic v1_zero;
   logic unused_bits;

   assign v1_neg  = D_V1[WIDTH-1];
   assign v1_zero = (D_V1 == '0);

   always_comb begin
      taken = 1'b0;
      case (CMPOp)
         3'b000:  taken = (D_V1 == D_V2);
         3'b001:  taken = (D_V1 != D_V2);
         3'b010:  taken = v1_neg || v1_zero;
         3'b011:  taken = !v1_neg && !v1_zero;
         3'b100:  taken = v1_neg;
         3'b101:  taken = !v1_neg;
         default: taken = 1'b0;
      endcase
   end

   assign in_ready = !out_valid_q || out_ready;
   assign fire     = in_valid && in_ready;

`ifdef BRANCH_PRED_EN
   logic [1:0]       ctr_q [ENTRIES];
   logic [1:0]       ctr_d [ENTRIES];
   logic [IDX_W-1:0] d_idx;
   logic [IDX_W-1:0] f_idx;

   assign d_idx  = d_pc[IDX_W+1:2];
   assign f_idx  = f_pc[IDX_W+1:2];
   assign mis    = taken ^ d_pred_taken;
   // Reads ctr_q, so a same-cycle update is not visible yet.
   assign f_pred = ctr_q[f_idx][1];

   always_comb begin
      ctr_d = ctr_q;
      if (fire) begin
         if (taken && ctr_q[d_idx] != 2'b11)
            ctr_d[d_idx] = ctr_q[d_idx] + 2'b01;
         else if (!taken && ctr_q[d_idx] != 2'b00)
            ctr_d[d_idx] = ctr_q[d_idx] - 2'b01;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ENTRIES; i++)
            ctr_q[i] <= 2'b01;
      end else begin
         ctr_q <= ctr_d;
      end
   end

   assign unused_bits = ^{d_pc[WIDTH-1:IDX_W+2], d_pc[1:0],
                          f_pc[WIDTH-1:IDX_W+2], f_pc[1:0]};
`else
   assign mis         = taken;
   assign f_pred      = 1'b0;
   assign unused_bits = ^{d_pc, f_pc, d_pred_taken};
`endif

   always_comb begin
      out_valid_d = out_valid_q;
      b_result_d  = b_result_q;
      mispred_d   = mispred_q;
      mcnt_d      = mcnt_q;
      if (fire) begin
         out_valid_d = 1'b1;
         b_result_d  = taken;
         mispred_d   = mis;
         if (mis && mcnt_q != 32'hFFFF_FFFF)
            mcnt_d = mcnt_q + 32'd1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         b_result_q  <= 1'b0;
         mispred_q   <= 1'b0;
         mcnt_q      <= 32'd0;
      end else begin
         out_valid_q <= out_valid_d;
         b_result_q  <= b_result_d;
         mispred_q   <= mispred_d;
         mcnt_q      <= mcnt_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign b_result       = b_result_q;
   assign mispredict     = mispred_q;
   assign mispredict_cnt = mcnt_q;

endmodule
